// File: rtl/sram_b_port_arbiter.sv
// sram_b_port_arbiter: arbitrates two requesters onto a 1W/1R SRAM and buffers one read response per requester
module sram_b_port_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_we,
    input  logic [1:0][15:0] req_addr,
    input  logic [1:0][7:0]  req_data,
    input  logic [1:0][7:0]  req_wem,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [1:0][7:0]  rsp_data,
    output logic             CE0,
    output logic [15:0]      A0,
    output logic [7:0]       D0,
    output logic             WE0,
    output logic [7:0]       WEM0,
    output logic             CE1,
    output logic [15:0]      A1,
    input  logic [7:0]       Q1,
    output logic [15:0]      conflict_cnt
);
    logic [1:0] inflight;
    logic       w_ptr;
    logic       r_ptr;
    logic [1:0] w_cand;
    logic [1:0] r_cand;
    logic       w_any;
    logic       r_any;
    logic       w_sel;
    logic       r_sel;
    logic       conflict;
    logic       r_fire;

    // pick one writer and one reader per cycle; a same-address read yields to the write
    always_comb begin
        w_cand    = RSTN ? req_valid & req_we : 2'b00;
        r_cand    = RSTN ? req_valid & ~req_we & ~inflight & ~rsp_valid : 2'b00;
        w_any     = |w_cand;
        r_any     = |r_cand;
        w_sel     = (&w_cand) ? (RR_EN ? w_ptr : 1'b0) : w_cand[1];
        r_sel     = (&r_cand) ? (RR_EN ? r_ptr : 1'b0) : r_cand[1];
        conflict  = w_any && r_any && (req_addr[w_sel] == req_addr[r_sel]);
        r_fire    = r_any && !conflict;
        CE0       = w_any;
        WE0       = w_any;
        A0        = w_any ? req_addr[w_sel] : 16'h0000;
        D0        = w_any ? req_data[w_sel] : 8'h00;
        WEM0      = w_any ? req_wem[w_sel] : 8'h00;
        CE1       = r_fire;
        A1        = r_fire ? req_addr[r_sel] : 16'h0000;
        req_ready = ({w_sel, ~w_sel} & {2{w_any}}) | ({r_sel, ~r_sel} & {2{r_fire}});
    end

    // pointers, conflict counter and the two-stage read return path
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            w_ptr        <= 1'b0;
            r_ptr        <= 1'b0;
            conflict_cnt <= 16'h0000;
            inflight     <= 2'b00;
            rsp_valid    <= 2'b00;
            rsp_data     <= '0;
        end else begin
            if (w_any) w_ptr <= ~w_sel;
            if (r_fire) r_ptr <= ~r_sel;
            if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
            inflight <= {r_sel, ~r_sel} & {2{r_fire}};
            for (int i = 0; i < 2; i++) begin
                if (inflight[i]) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_data[i]  <= Q1;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_b_port_arbiter.sv
// tb_sram_b_port_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_sram_b_port_arbiter;
    logic             CLK = 1'b0;
    logic             RSTN = 1'b0;
    logic [1:0]       req_valid, req_we, rsp_ready;
    logic [1:0][15:0] req_addr;
    logic [1:0][7:0]  req_data, req_wem;
    logic [1:0]       req_ready, rsp_valid, f_req_ready, f_rsp_valid;
    logic [1:0][7:0]  rsp_data, f_rsp_data;
    logic             CE0, WE0, CE1, f_CE0, f_WE0, f_CE1;
    logic [15:0]      A0, A1, f_A0, f_A1, conflict_cnt, f_conflict_cnt;
    logic [7:0]       D0, WEM0, f_D0, f_WEM0;
    logic [7:0]       Q1 = '0;
    bit   [7:0]       mem [65536];
    bit   [7:0]       ref_mem [65536];
    int               n_vec = 0;
    int               n_err = 0;

    always #5 CLK = ~CLK;

    sram_b_port_arbiter #(.RR_EN(1'b1)) dut (
        .CLK(CLK), .RSTN(RSTN), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data), .req_wem(req_wem), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0),
        .WEM0(WEM0), .CE1(CE1), .A1(A1), .Q1(Q1), .conflict_cnt(conflict_cnt)
    );

    sram_b_port_arbiter #(.RR_EN(1'b0)) dut_fixed (
        .CLK(CLK), .RSTN(RSTN), .req_valid(req_valid), .req_ready(f_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data), .req_wem(req_wem), .rsp_valid(f_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(f_rsp_data), .CE0(f_CE0), .A0(f_A0), .D0(f_D0), .WE0(f_WE0),
        .WEM0(f_WEM0), .CE1(f_CE1), .A1(f_A1), .Q1(Q1), .conflict_cnt(f_conflict_cnt)
    );

    // SRAM behind the main instance: masked write, read data one cycle after CE1
    always @(posedge CLK) begin
        if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
        if (CE1) Q1 <= mem[A1];
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        req_wem   = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [15:0] a, input logic [7:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_data[i]  = d;
        req_wem[i]   = 8'hFF;
    endtask

    function automatic int pick(input logic [1:0] c, input int p);
        if (c == 2'b11) return p;
        if (c[0]) return 0;
        if (c[1]) return 1;
        return -1;
    endfunction

    task automatic test_reset();
        RSTN = 1'b0;
        rsp_ready = 2'b11;
        set_req(0, 1'b1, 16'h0001, 8'h11);
        set_req(1, 1'b0, 16'h0002, 8'h00);
        cyc();
        cyc();
        n_vec++;
        if ({req_ready, CE0, CE1, f_req_ready, f_CE0, f_CE1} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_grants: got %b want 000000", {req_ready, CE0, CE1, f_req_ready, f_CE0, f_CE1});
        end
        n_vec++;
        if ({rsp_valid, rsp_data, conflict_cnt} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", {rsp_valid, rsp_data, conflict_cnt});
        end
        n_vec++;
        if ({A0, D0, WEM0, A1} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_buses: got %h want 0", {A0, D0, WEM0, A1});
        end
        idle();
        rsp_ready = 2'b00;
        RSTN = 1'b1;
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, 16'h4001, 8'hA5);
        #1;
        n_vec++;
        if ({req_ready, CE0, WE0, A0, D0, WEM0, CE1} !== {2'b01, 1'b1, 1'b1, 16'h4001, 8'hA5, 8'hFF, 1'b0}) begin
            n_err++;
            $display("FAIL wr_issue: got %h want %h", {req_ready, CE0, WE0, A0, D0, WEM0, CE1},
                     {2'b01, 1'b1, 1'b1, 16'h4001, 8'hA5, 8'hFF, 1'b0});
        end
        cyc();
        idle();
        set_req(0, 1'b0, 16'h4001, 8'h00);
        #1;
        n_vec++;
        if ({req_ready, CE1, A1, CE0} !== {2'b01, 1'b1, 16'h4001, 1'b0}) begin
            n_err++;
            $display("FAIL rd_issue: got %h want %h", {req_ready, CE1, A1, CE0}, {2'b01, 1'b1, 16'h4001, 1'b0});
        end
        cyc();
        idle();
        #1;
        n_vec++;
        if (rsp_valid !== 2'b00) begin
            n_err++;
            $display("FAIL rd_early: got %b want 00", rsp_valid);
        end
        cyc();
        n_vec++;
        if ({rsp_valid, rsp_data[0]} !== {2'b01, 8'hA5}) begin
            n_err++;
            $display("FAIL rd_data: got %h want %h", {rsp_valid, rsp_data[0]}, {2'b01, 8'hA5});
        end
        rsp_ready = 2'b01;
        cyc();
        rsp_ready = 2'b00;
        n_vec++;
        if (rsp_valid !== 2'b00) begin
            n_err++;
            $display("FAIL rd_handshake: got %b want 00", rsp_valid);
        end
    endtask

    task automatic test_concurrent();
        set_req(0, 1'b1, 16'h0010, 8'h3C);
        set_req(1, 1'b0, 16'hC000, 8'h00);
        #1;
        n_vec++;
        if ({req_ready, CE0, CE1, A0, A1} !== {2'b11, 1'b1, 1'b1, 16'h0010, 16'hC000}) begin
            n_err++;
            $display("FAIL concurrent_issue: got %h want %h", {req_ready, CE0, CE1, A0, A1},
                     {2'b11, 1'b1, 1'b1, 16'h0010, 16'hC000});
        end
        cyc();
        idle();
        #1;
        n_vec++;
        if (conflict_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL concurrent_cnt: got %0d want 0", conflict_cnt);
        end
        cyc();
        n_vec++;
        if ({rsp_valid, rsp_data[1]} !== {2'b10, 8'h00}) begin
            n_err++;
            $display("FAIL concurrent_rsp: got %h want %h", {rsp_valid, rsp_data[1]}, {2'b10, 8'h00});
        end
        rsp_ready = 2'b10;
        cyc();
        rsp_ready = 2'b00;
    endtask

    task automatic test_conflict();
        set_req(0, 1'b1, 16'h1234, 8'h5A);
        set_req(1, 1'b0, 16'h1234, 8'h00);
        #1;
        n_vec++;
        if ({req_ready, CE0, CE1, A0, A1} !== {2'b01, 1'b1, 1'b0, 16'h1234, 16'h0000}) begin
            n_err++;
            $display("FAIL conflict_defer: got %h want %h", {req_ready, CE0, CE1, A0, A1},
                     {2'b01, 1'b1, 1'b0, 16'h1234, 16'h0000});
        end
        cyc();
        req_valid[0] = 1'b0;
        req_we[0] = 1'b0;
        #1;
        n_vec++;
        if ({conflict_cnt, req_ready, CE0, CE1, A1} !== {16'd1, 2'b10, 1'b0, 1'b1, 16'h1234}) begin
            n_err++;
            $display("FAIL conflict_retry: got %h want %h", {conflict_cnt, req_ready, CE0, CE1, A1},
                     {16'd1, 2'b10, 1'b0, 1'b1, 16'h1234});
        end
        cyc();
        idle();
        cyc();
        n_vec++;
        if ({rsp_valid, rsp_data[1]} !== {2'b10, 8'h5A}) begin
            n_err++;
            $display("FAIL conflict_data: got %h want %h", {rsp_valid, rsp_data[1]}, {2'b10, 8'h5A});
        end
        rsp_ready = 2'b10;
        cyc();
        rsp_ready = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [25:0] exp_rr;
        RSTN = 1'b0;
        idle();
        cyc();
        RSTN = 1'b1;
        set_req(0, 1'b1, 16'h0A00, 8'h11);
        set_req(1, 1'b1, 16'h0B00, 8'h22);
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_rr = (k % 2 == 0) ? {2'b01, 16'h0A00, 8'h11} : {2'b10, 16'h0B00, 8'h22};
            n_vec++;
            if ({req_ready, A0, D0} !== exp_rr) begin
                n_err++;
                $display("FAIL rr_grant%0d: got %h want %h", k, {req_ready, A0, D0}, exp_rr);
            end
            n_vec++;
            if ({f_req_ready, f_A0} !== {2'b01, 16'h0A00}) begin
                n_err++;
                $display("FAIL fixed_grant%0d: got %h want %h", k, {f_req_ready, f_A0}, {2'b01, 16'h0A00});
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_backpressure();
        set_req(1, 1'b0, 16'h0B00, 8'h00);
        #1;
        n_vec++;
        if (req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL bp_accept: got %b want 10", req_ready);
        end
        cyc();
        req_addr[1] = 16'h0A00;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++;
            if ({rsp_valid[1], rsp_data[1], req_ready[1]} !== {1'b1, 8'h22, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got %h want %h", k, {rsp_valid[1], rsp_data[1], req_ready[1]},
                         {1'b1, 8'h22, 1'b0});
            end
            cyc();
        end
        rsp_ready[1] = 1'b1;
        #1;
        n_vec++;
        if (req_ready[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_reuse: got %b want 0", req_ready[1]);
        end
        cyc();
        rsp_ready[1] = 1'b0;
        #1;
        n_vec++;
        if ({rsp_valid[1], req_ready[1], A1} !== {1'b0, 1'b1, 16'h0A00}) begin
            n_err++;
            $display("FAIL bp_reissue: got %h want %h", {rsp_valid[1], req_ready[1], A1}, {1'b0, 1'b1, 16'h0A00});
        end
        cyc();
        idle();
        cyc();
        n_vec++;
        if ({rsp_valid[1], rsp_data[1]} !== {1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL bp_second: got %h want %h", {rsp_valid[1], rsp_data[1]}, {1'b1, 8'h11});
        end
        rsp_ready = 2'b10;
        cyc();
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_midread();
        set_req(0, 1'b1, 16'h0C00, 8'h77);
        set_req(1, 1'b0, 16'h0C00, 8'h00);
        cyc();
        idle();
        set_req(0, 1'b0, 16'h0A00, 8'h00);
        #1;
        n_vec++;
        if ({conflict_cnt, req_ready} !== {16'd1, 2'b01}) begin
            n_err++;
            $display("FAIL mid_setup: got %h want %h", {conflict_cnt, req_ready}, {16'd1, 2'b01});
        end
        cyc();
        idle();
        RSTN = 1'b0;
        cyc();
        RSTN = 1'b1;
        #1;
        n_vec++;
        if ({rsp_valid, conflict_cnt} !== 18'h0) begin
            n_err++;
            $display("FAIL mid_cleared: got %h want 0", {rsp_valid, conflict_cnt});
        end
        cyc();
        cyc();
        n_vec++;
        if (rsp_valid !== 2'b00) begin
            n_err++;
            $display("FAIL mid_no_rsp: got %b want 00", rsp_valid);
        end
        set_req(0, 1'b1, 16'h0D00, 8'h01);
        set_req(1, 1'b1, 16'h0D01, 8'h02);
        #1;
        n_vec++;
        if ({req_ready, A0} !== {2'b01, 16'h0D00}) begin
            n_err++;
            $display("FAIL mid_wptr: got %h want %h", {req_ready, A0}, {2'b01, 16'h0D00});
        end
        cyc();
        set_req(0, 1'b0, 16'h0E00, 8'h00);
        set_req(1, 1'b0, 16'h0E01, 8'h00);
        #1;
        n_vec++;
        if ({req_ready, A1} !== {2'b01, 16'h0E00}) begin
            n_err++;
            $display("FAIL mid_rptr: got %h want %h", {req_ready, A1}, {2'b01, 16'h0E00});
        end
        cyc();
        idle();
    endtask

    task automatic test_random();
        int          wp, rp, cnt, gw, gr;
        int          stage [2];
        logic [7:0]  pend [2];
        logic [7:0]  held [2];
        logic        conf;
        logic [1:0]  e_ready;
        logic [15:0] e_a0, e_a1;
        logic [7:0]  e_d0, e_wm;
        logic [52:0] exp_g;
        logic [33:0] exp_r;
        RSTN = 1'b0;
        idle();
        rsp_ready = 2'b00;
        cyc();
        RSTN = 1'b1;
        wp = 0;
        rp = 0;
        cnt = 0;
        stage = '{0, 0};
        pend = '{8'h00, 8'h00};
        held = '{8'h00, 8'h00};
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = 1'($urandom_range(0, 3) != 0);
                req_we[i]    = 1'($urandom);
                req_addr[i]  = 16'h5500 + 16'($urandom_range(0, 3));
                req_data[i]  = 8'($urandom);
                req_wem[i]   = 8'($urandom);
                rsp_ready[i] = 1'($urandom);
            end
            #1;
            gw = pick(req_valid & req_we, wp);
            gr = pick(req_valid & ~req_we & {stage[1] == 0, stage[0] == 0}, rp);
            conf = (gw >= 0) && (gr >= 0) && (req_addr[gw] == req_addr[gr]);
            if (conf) gr = -1;
            e_ready = 2'b00;
            e_a0 = '0;
            e_d0 = '0;
            e_wm = '0;
            e_a1 = '0;
            if (gw >= 0) begin
                e_ready[gw] = 1'b1;
                e_a0 = req_addr[gw];
                e_d0 = req_data[gw];
                e_wm = req_wem[gw];
            end
            if (gr >= 0) begin
                e_ready[gr] = 1'b1;
                e_a1 = req_addr[gr];
            end
            exp_g = {e_ready, gw >= 0, gw >= 0, e_a0, e_d0, e_wm, gr >= 0, e_a1};
            exp_r = {stage[1] == 2, stage[0] == 2, held[1], held[0], 16'(cnt)};
            n_vec++;
            if ({req_ready, CE0, WE0, A0, D0, WEM0, CE1, A1} !== exp_g) begin
                n_err++;
                $display("FAIL rand_grant@%0d: got %h want %h", n, {req_ready, CE0, WE0, A0, D0, WEM0, CE1, A1}, exp_g);
            end
            n_vec++;
            if ({rsp_valid, rsp_data, conflict_cnt} !== exp_r) begin
                n_err++;
                $display("FAIL rand_rsp@%0d: got %h want %h", n, {rsp_valid, rsp_data, conflict_cnt}, exp_r);
            end
            for (int i = 0; i < 2; i++) begin
                if (stage[i] == 2 && rsp_ready[i]) stage[i] = 0;
                else if (stage[i] == 1) begin
                    stage[i] = 2;
                    held[i] = pend[i];
                end
            end
            if (gr >= 0) begin
                stage[gr] = 1;
                pend[gr] = ref_mem[req_addr[gr]];
                rp = 1 - gr;
            end
            if (gw >= 0) begin
                ref_mem[req_addr[gw]] = (ref_mem[req_addr[gw]] & ~req_wem[gw]) | (req_data[gw] & req_wem[gw]);
                wp = 1 - gw;
            end
            if (conf && cnt < 65535) cnt++;
            cyc();
        end
        idle();
        rsp_ready = 2'b00;
    endtask

    task automatic test_saturation();
        RSTN = 1'b0;
        idle();
        cyc();
        RSTN = 1'b1;
        set_req(0, 1'b1, 16'h7000, 8'h00);
        set_req(1, 1'b0, 16'h7000, 8'h00);
        repeat (65534) cyc();
        n_vec++;
        if (conflict_cnt !== 16'hFFFE) begin
            n_err++;
            $display("FAIL sat_before: got %h want fffe", conflict_cnt);
        end
        cyc();
        n_vec++;
        if (conflict_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_reach: got %h want ffff", conflict_cnt);
        end
        repeat (3) cyc();
        n_vec++;
        if ({conflict_cnt, CE1, CE0} !== {16'hFFFF, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sat_hold: got %h want %h", {conflict_cnt, CE1, CE0}, {16'hFFFF, 1'b0, 1'b1});
        end
        idle();
    endtask

    initial begin
        idle();
        rsp_ready = 2'b00;
        test_reset();
        test_write_read();
        test_concurrent();
        test_conflict();
        test_round_robin();
        test_backpressure();
        test_reset_midread();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
